// File: rtl/pc_fetch_seq_pkg.sv
// Shared types and constants for the PC / fetch sequencer.
package pc_fetch_seq_pkg;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } fetch_state_e;

    localparam int PC_STEP    = 4;
    localparam int WORD_SHIFT = 2;
    localparam int ADDR_W_DEF = 32;

    typedef logic [ADDR_W_DEF-1:0] addr_t;

endpackage

// File: rtl/pc_fetch_seq_target_calc.sv
// Branch target (br_pc + sign-extended word offset * 4) and sequential PC+4.
module pc_target_calc
    import pc_fetch_seq_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] br_pc,
    input  logic [31:0]       br_off,
    output logic [ADDR_W-1:0] pc_inc,
    output logic [ADDR_W-1:0] target
);

    localparam int EXT_W = (ADDR_W > 32) ? ADDR_W : 32;

    logic [EXT_W-1:0] off_ext;
    logic [EXT_W-1:0] off_shift;

    always_comb begin
        off_ext   = EXT_W'(signed'(br_off));
        off_shift = off_ext << WORD_SHIFT;
        // Both sums wrap naturally at ADDR_W bits.
        target    = br_pc + off_shift[ADDR_W-1:0];
        pc_inc    = pc + ADDR_W'(PC_STEP);
    end

endmodule

// File: rtl/pc_fetch_seq.sv
// PC owner and single-outstanding fetch sequencer with redirect/flush handling.
module pc_fetch_seq
    import pc_fetch_seq_pkg::*;
#(
    parameter int              ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [31:0]       imem_rsp_data,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instr_data,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              pc_take,
    input  logic [ADDR_W-1:0] br_pc,
    input  logic [31:0]       br_off,
    output logic [CNT_W-1:0]  redirect_cnt
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              req_valid_q, req_valid_d;
    logic              instr_valid_q, instr_valid_d;
    logic [31:0]       instr_data_q, instr_data_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
    logic              discard_q, discard_d;
    logic [CNT_W-1:0]  redirect_cnt_q, redirect_cnt_d;

    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] target;

    pc_target_calc #(.ADDR_W(ADDR_W)) u_target_calc (
        .pc     (pc_q),
        .br_pc  (br_pc),
        .br_off (br_off),
        .pc_inc (pc_inc),
        .target (target)
    );

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        discard_d      = discard_q;
        instr_data_d   = instr_data_q;
        instr_pc_d     = instr_pc_q;
        redirect_cnt_d = redirect_cnt_q;

        case (state_q)
            REQ: begin
                if (req_valid_q && imem_req_ready) begin
                    state_d = WAIT;
                    // Old address is already in flight; its response must be dropped.
                    if (pc_take) discard_d = 1'b1;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    if (discard_q || pc_take) begin
                        discard_d = 1'b0;
                        state_d   = REQ;
                    end else begin
                        instr_data_d = imem_rsp_data;
                        instr_pc_d   = pc_q;
                        pc_d         = pc_inc;
                        state_d      = HOLD;
                    end
                end else if (pc_take) begin
                    discard_d = 1'b1;
                end
            end
            HOLD: begin
                if (pc_take || instr_ready) state_d = REQ;
            end
            default: state_d = REQ;
        endcase

        if (pc_take) begin
            pc_d = target;
            if (redirect_cnt_q != {CNT_W{1'b1}}) redirect_cnt_d = redirect_cnt_q + 1'b1;
        end

        req_valid_d   = (state_d == REQ);
        instr_valid_d = (state_d == HOLD);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= REQ;
            pc_q           <= RESET_PC;
            req_valid_q    <= 1'b0;
            instr_valid_q  <= 1'b0;
            instr_data_q   <= '0;
            instr_pc_q     <= '0;
            discard_q      <= 1'b0;
            redirect_cnt_q <= '0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            req_valid_q    <= req_valid_d;
            instr_valid_q  <= instr_valid_d;
            instr_data_q   <= instr_data_d;
            instr_pc_q     <= instr_pc_d;
            discard_q      <= discard_d;
            redirect_cnt_q <= redirect_cnt_d;
        end
    end

    assign imem_req_valid = req_valid_q;
    assign imem_req_addr  = pc_q;
    assign instr_valid    = instr_valid_q;
    assign instr_data     = instr_data_q;
    assign instr_pc       = instr_pc_q;
    assign redirect_cnt   = redirect_cnt_q;

endmodule

// File: tb/tb_pc_fetch_seq.sv
// Directed bench for pc_fetch_seq: fetch, stall, redirects, wrap, saturation, reset mid-fetch.
module tb_pc_fetch_seq;
    import pc_fetch_seq_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    addr_t       imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    addr_t       instr_pc;
    logic        pc_take;
    addr_t       br_pc;
    logic [31:0] br_off;
    logic [7:0]  redirect_cnt;

    int vectors     = 0;
    int miscompares = 0;

    pc_fetch_seq #(.ADDR_W(32), .RESET_PC(32'h0), .CNT_W(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .pc_take        (pc_take),
        .br_pc          (br_pc),
        .br_off         (br_off),
        .redirect_cnt   (redirect_cnt)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_fetch(input logic [31:0] d);
        int n = 0;
        while (!imem_req_valid && n < 20) begin
            tick();
            n++;
        end
        vectors++;
        if (!imem_req_valid) begin
            miscompares++;
            $display("FAIL fetch_req_timeout: req_valid=%0b exp 1", imem_req_valid);
        end
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        tick();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = d;
        tick();
        imem_rsp_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        vectors++;
        if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0 || imem_req_addr !== 32'h0 ||
            instr_data !== 32'h0 || instr_pc !== 32'h0 || redirect_cnt !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_values: rv=%0b iv=%0b addr=%h data=%h ipc=%h cnt=%0d exp all zero",
                     imem_req_valid, instr_valid, imem_req_addr, instr_data, instr_pc, redirect_cnt);
        end
        reset = 1'b0;
        tick();
        vectors++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
            miscompares++;
            $display("FAIL first_req: rv=%0b addr=%h exp 1/00000000", imem_req_valid, imem_req_addr);
        end
    endtask

    task automatic test_basic_fetch();
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        vectors++;
        if (imem_req_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL req_drop_after_accept: rv=%0b exp 0", imem_req_valid);
        end
        tick();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h1234_5678;
        tick();
        imem_rsp_valid = 1'b0;
        vectors++;
        if (instr_valid !== 1'b1 || instr_data !== 32'h1234_5678 || instr_pc !== 32'h0) begin
            miscompares++;
            $display("FAIL first_instr: iv=%0b data=%h pc=%h exp 1/12345678/00000000",
                     instr_valid, instr_data, instr_pc);
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        vectors++;
        if (instr_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h4) begin
            miscompares++;
            $display("FAIL second_req: iv=%0b rv=%0b addr=%h exp 0/1/00000004",
                     instr_valid, imem_req_valid, imem_req_addr);
        end
    endtask

    task automatic test_stall();
        do_fetch(32'hCAFE_0004);
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (instr_valid !== 1'b1 || instr_data !== 32'hCAFE_0004 || instr_pc !== 32'h4 ||
                imem_req_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL stall_hold[%0d]: iv=%0b data=%h pc=%h rv=%0b exp 1/cafe0004/00000004/0",
                         i, instr_valid, instr_data, instr_pc, imem_req_valid);
            end
            tick();
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        vectors++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8 || instr_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_release: rv=%0b addr=%h iv=%0b exp 1/00000008/0",
                     imem_req_valid, imem_req_addr, instr_valid);
        end
    endtask

    task automatic test_redirect_wait();
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        pc_take = 1'b1;
        br_pc   = 32'h10;
        br_off  = -32'sd2;
        tick();
        pc_take = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        tick();
        imem_rsp_valid = 1'b0;
        vectors++;
        if (instr_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8 ||
            redirect_cnt !== 8'd1) begin
            miscompares++;
            $display("FAIL redirect_wait: iv=%0b rv=%0b addr=%h cnt=%0d exp 0/1/00000008/1",
                     instr_valid, imem_req_valid, imem_req_addr, redirect_cnt);
        end
        tick();
        vectors++;
        if (instr_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL redirect_wait_no_instr: iv=%0b exp 0", instr_valid);
        end
    endtask

    task automatic test_redirect_same_cycle();
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hBAD0_0008;
        pc_take = 1'b1;
        br_pc   = 32'h100;
        br_off  = 32'd3;
        tick();
        imem_rsp_valid = 1'b0;
        pc_take = 1'b0;
        vectors++;
        if (instr_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h10C ||
            redirect_cnt !== 8'd2) begin
            miscompares++;
            $display("FAIL redirect_same_cycle: iv=%0b rv=%0b addr=%h cnt=%0d exp 0/1/0000010c/2",
                     instr_valid, imem_req_valid, imem_req_addr, redirect_cnt);
        end
    endtask

    task automatic test_redirect_hold();
        do_fetch(32'h0000_010C);
        vectors++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h10C) begin
            miscompares++;
            $display("FAIL hold_before_redirect: iv=%0b pc=%h exp 1/0000010c", instr_valid, instr_pc);
        end
        pc_take     = 1'b1;
        instr_ready = 1'b1;
        br_pc       = 32'h200;
        br_off      = 32'hFFFF_FFFF;
        tick();
        pc_take     = 1'b0;
        instr_ready = 1'b0;
        vectors++;
        if (instr_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h1FC ||
            redirect_cnt !== 8'd3) begin
            miscompares++;
            $display("FAIL redirect_hold: iv=%0b rv=%0b addr=%h cnt=%0d exp 0/1/000001fc/3",
                     instr_valid, imem_req_valid, imem_req_addr, redirect_cnt);
        end
    endtask

    task automatic test_wrap_and_saturate();
        pc_take = 1'b1;
        br_pc   = 32'hFFFF_FFFC;
        br_off  = 32'd1;
        tick();
        pc_take = 1'b0;
        vectors++;
        if (imem_req_addr !== 32'h0 || imem_req_valid !== 1'b1 || redirect_cnt !== 8'd4) begin
            miscompares++;
            $display("FAIL target_wrap: addr=%h rv=%0b cnt=%0d exp 00000000/1/4",
                     imem_req_addr, imem_req_valid, redirect_cnt);
        end
        pc_take = 1'b1;
        br_pc   = 32'h40;
        br_off  = 32'd0;
        tick();
        br_pc   = 32'h80;
        br_off  = 32'd4;
        tick();
        pc_take = 1'b0;
        vectors++;
        if (imem_req_addr !== 32'h90 || redirect_cnt !== 8'd6) begin
            miscompares++;
            $display("FAIL last_target_wins: addr=%h cnt=%0d exp 00000090/6", imem_req_addr, redirect_cnt);
        end
        pc_take = 1'b1;
        br_pc   = 32'h20;
        br_off  = 32'd0;
        for (int i = 0; i < 260; i++) tick();
        pc_take = 1'b0;
        vectors++;
        if (redirect_cnt !== 8'd255 || imem_req_addr !== 32'h20) begin
            miscompares++;
            $display("FAIL cnt_saturate: cnt=%0d addr=%h exp 255/00000020", redirect_cnt, imem_req_addr);
        end
    endtask

    task automatic test_reset_mid_fetch();
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        reset = 1'b1;
        tick();
        vectors++;
        if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0 || imem_req_addr !== 32'h0 ||
            instr_data !== 32'h0 || instr_pc !== 32'h0 || redirect_cnt !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_mid_fetch: rv=%0b iv=%0b addr=%h data=%h ipc=%h cnt=%0d exp all zero",
                     imem_req_valid, instr_valid, imem_req_addr, instr_data, instr_pc, redirect_cnt);
        end
        reset = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h5555_AAAA;
        tick();
        imem_rsp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (instr_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
                miscompares++;
                $display("FAIL late_rsp_ignored[%0d]: iv=%0b rv=%0b addr=%h exp 0/1/00000000",
                         i, instr_valid, imem_req_valid, imem_req_addr);
            end
            tick();
        end
    endtask

    initial begin
        reset          = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        instr_ready    = 1'b0;
        pc_take        = 1'b0;
        br_pc          = 32'h0;
        br_off         = 32'h0;

        test_reset();
        test_basic_fetch();
        test_stall();
        test_redirect_wait();
        test_redirect_same_cycle();
        test_redirect_hold();
        test_wrap_and_saturate();
        test_reset_mid_fetch();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pc_fetch_seq.md
Name: pc_fetch_seq

Overview:
- Program-counter and fetch sequencer that consumes the branch-taken decision from the PC condition logic.
- Owns the architectural PC and issues word fetches to instruction memory over a valid/ready request and valid response interface.
- Presents fetched instructions to decode over a valid/ready interface.
- Applies redirects: target = branch PC + (word offset << 2), flushing any in-flight or held instruction.

Parameters:
- ADDR_W, 32, PC and memory address width.
- RESET_PC, 0, PC value loaded on reset.
- CNT_W, 8, width of the saturating redirect counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_req_addr  out  ADDR_W  fetch address; always equals the current PC.
- imem_rsp_valid  in  1  one-cycle pulse carrying the response.
- imem_rsp_data  in  32  fetched instruction word.
- instr_valid  out  1  instruction available to decode.
- instr_ready  in  1  decode accepts the instruction.
- instr_data  out  32  held instruction word.
- instr_pc  out  ADDR_W  PC of the held instruction.
- pc_take  in  1  branch/jump taken; one-cycle pulse from the PC condition logic.
- br_pc  in  ADDR_W  PC of the redirecting instruction.
- br_off  in  32  signed word offset.
- redirect_cnt  out  CNT_W  count of accepted redirects; saturating.

Behaviour:
- Reset values: state=REQ, pc=RESET_PC, imem_req_valid=0, instr_valid=0, instr_data=0, instr_pc=0, discard=0, redirect_cnt=0.
- The first request is asserted in the cycle after reset deasserts.
- imem_req_valid is registered and equals (state==REQ) after the first post-reset cycle.
- Target arithmetic: target = br_pc + (sign-extended br_off << 2), truncated to ADDR_W bits; wraps modulo 2^ADDR_W.
- Sequential increment: pc+4, also wraps modulo 2^ADDR_W.
- One outstanding fetch maximum; no prefetch.
- REQ: imem_req_valid=1.
  - On imem_req_ready, go to WAIT.
  - The address may change while valid is high and not yet accepted, only because of a redirect. Memory samples the address only on the handshake.
- WAIT: waits for imem_rsp_valid.
  - discard=0: latch instr_data=imem_rsp_data and instr_pc=pc, set pc<=pc+4, go to HOLD. instr_valid=1 from the next cycle.
  - discard=1: drop the response, clear discard, go to REQ.
- HOLD: instr_valid stays 1 and data is stable until instr_ready. On the handshake, go to REQ and drop instr_valid next cycle.
- Redirect (pc_take=1): pc<=target, redirect_cnt increments and saturates at 2^CNT_W-1. The redirect has priority over pc+4. Per state:
  - REQ without handshake: stay in REQ; the next cycle's address is the target.
  - REQ with handshake in the same cycle: the old address is in flight. Set discard=1, go to WAIT.
  - WAIT: set discard=1. If imem_rsp_valid arrives in the same cycle, that response is discarded; clear discard and go to REQ.
  - HOLD: instr_valid drops next cycle regardless of instr_ready, then go to REQ. If instr_ready is also high that cycle, the handshake counts as consumed.
- imem_rsp_valid outside WAIT is ignored.
- pc_take high on consecutive cycles: the last target wins.
- Reset during any state, including mid-fetch: immediate return to reset values. Late responses arriving afterwards are ignored because the state is REQ.

Decomposition:
- Shared package holds:
  - state enum: REQ, WAIT, HOLD.
  - PC_STEP=4.
  - WORD_SHIFT=2.
  - typedef for ADDR_W-bit address.
- One natural sub-module, pc_target_calc: combinational sign-extend, shift and add for target, plus the +4 incrementer.

Test Plan:
- Reset then imem_req_ready=1 with the response 2 cycles later → first imem_req_addr=0x0; instr_pc=0x0 and instr_data=response; next request addr=0x4.
- Decode stalled (instr_ready=0 for 5 cycles) → instr_valid held, instr_data stable, no new request; accept → request at 0x8 next cycle.
- pc_take in WAIT with br_pc=0x10 and br_off=-2 → in-flight response dropped (instr_valid stays 0); next request addr=0x8; redirect_cnt=1.
- pc_take in the same cycle as imem_rsp_valid → response discarded; request at target.
- pc_take in HOLD with instr_ready=1 → instr_valid low next cycle; request at target.
- br_pc=0xFFFFFFFC, br_off=+1 → target wraps to 0x0; 256 redirects → redirect_cnt=255.
- Reset asserted during WAIT → all outputs return to reset values; a late imem_rsp_valid causes no instr_valid.
